// File: rtl/calc_engine_if.sv
// Token handshake and display bus between the keypad decoder (master)
// and the calculator engine (slave).
interface calc_engine_if #(
    parameter int WIDTH = 16
);
    logic             req;
    logic [3:0]       key_num;
    logic [2:0]       key_op;
    logic             ack;
    logic             busy;
    logic [WIDTH-1:0] display_val;
    logic [WIDTH-1:0] remainder;
    logic [2:0]       cur_op;
    logic             neg;
    logic             err;

    modport master (
        output req, key_num, key_op,
        input  ack, busy, display_val, remainder, cur_op, neg, err
    );

    modport slave (
        input  req, key_num, key_op,
        output ack, busy, display_val, remainder, cur_op, neg, err
    );
endinterface

// File: rtl/calc_engine.sv
// Calculator engine: accepts digit/operator tokens over a four-phase
// req/ack handshake, keeps operands A/B and a pending operator, supports
// chained operations and divides with a multi-cycle restoring divider.
module calc_engine #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    calc_engine_if.slave bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int DW = $clog2(WIDTH);

    localparam logic [2:0] OP_DIGIT = 3'd0;
    localparam logic [2:0] OP_DIV   = 3'd1;
    localparam logic [2:0] OP_ENT   = 3'd2;
    localparam logic [2:0] OP_CLR   = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd4;
    localparam logic [2:0] OP_SUB   = 3'd5;
    localparam logic [2:0] OP_ADD   = 3'd6;

    typedef enum logic [1:0] {S_A, S_B, S_DIV, S_ERR} state_t;

    state_t           state;
    logic [WIDTH-1:0] a, b, display_val, remainder, div_rem, div_quo;
    logic [CW-1:0]    a_cnt, b_cnt;
    logic [DW-1:0]    div_cnt;
    logic [2:0]       cur_op, next_op;
    logic             ack, busy, neg, err, fresh, div_chain;

    assign bus.ack         = ack;
    assign bus.busy        = busy;
    assign bus.display_val = display_val;
    assign bus.remainder   = remainder;
    assign bus.cur_op      = cur_op;
    assign bus.neg         = neg;
    assign bus.err         = err;

    // Candidate operand after appending the incoming digit; a shown result restarts A from zero.
    logic [WIDTH-1:0] dig_base;
    logic [CW-1:0]    dig_cnt;
    logic [WIDTH+3:0] dig_val;
    logic             dig_ok;
    always_comb begin
        dig_base = '0;
        dig_cnt  = '0;
        if (state == S_B) begin
            dig_base = b;
            dig_cnt  = b_cnt;
        end else if (!fresh) begin
            dig_base = a;
            dig_cnt  = a_cnt;
        end
        dig_val = ({4'b0000, dig_base} * (WIDTH+4)'(10)) + {{WIDTH{1'b0}}, bus.key_num};
        dig_ok  = (bus.key_num <= 4'd9) && (dig_cnt < CW'(MAX_DIGITS))
                  && (dig_val[WIDTH+3:WIDTH] == 4'b0000);
    end

    // Single-cycle result of the pending operator; DIV only reports divide-by-zero here.
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_neg, alu_err;
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        alu_res = '0;
        alu_neg = 1'b0;
        alu_err = 1'b0;
        case (cur_op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_err = sum[WIDTH];
            end
            OP_SUB: begin
                if (a >= b) begin
                    alu_res = a - b;
                end else begin
                    alu_res = b - a;
                    alu_neg = 1'b1;
                end
            end
            OP_MUL: begin
                alu_res = prod[WIDTH-1:0];
                alu_err = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV:  alu_err = (b == '0);
            default: ;
        endcase
    end

    // One restoring shift-subtract step; the remainder always stays below the divisor.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] rem_next, quo_next;
    always_comb begin
        div_shift = {div_rem, div_quo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b};
        rem_next  = div_ge ? (div_shift[WIDTH-1:0] - b) : div_shift[WIDTH-1:0];
        quo_next  = {div_quo[WIDTH-2:0], div_ge};
    end

    // Any operator other than ENT continues a chain instead of finishing to S_A.
    logic chain;
    assign chain = (bus.key_op != OP_ENT);

    // Main control FSM: handshake, token decode, chaining and divider sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_A;
            a           <= '0;
            b           <= '0;
            a_cnt       <= '0;
            b_cnt       <= '0;
            display_val <= '0;
            remainder   <= '0;
            div_rem     <= '0;
            div_quo     <= '0;
            div_cnt     <= '0;
            cur_op      <= '0;
            next_op     <= '0;
            ack         <= 1'b0;
            busy        <= 1'b0;
            neg         <= 1'b0;
            err         <= 1'b0;
            fresh       <= 1'b0;
            div_chain   <= 1'b0;
        end else begin
            if (ack && !bus.req) ack <= 1'b0;
            if (state == S_DIV) begin
                div_rem <= rem_next;
                div_quo <= quo_next;
                div_cnt <= div_cnt + DW'(1);
                if (div_cnt == DW'(WIDTH - 1)) begin
                    busy        <= 1'b0;
                    ack         <= 1'b1;
                    remainder   <= rem_next;
                    display_val <= quo_next;
                    a           <= quo_next;
                    neg         <= 1'b0;
                    if (div_chain) begin
                        cur_op <= next_op;
                        b      <= '0;
                        b_cnt  <= '0;
                        state  <= S_B;
                    end else begin
                        cur_op <= '0;
                        fresh  <= 1'b1;
                        state  <= S_A;
                    end
                end
            end else if (bus.req && !ack) begin
                ack <= 1'b1;
                if (bus.key_op == OP_CLR) begin
                    a           <= '0;
                    b           <= '0;
                    a_cnt       <= '0;
                    b_cnt       <= '0;
                    display_val <= '0;
                    remainder   <= '0;
                    cur_op      <= '0;
                    neg         <= 1'b0;
                    err         <= 1'b0;
                    fresh       <= 1'b0;
                    state       <= S_A;
                end else if (state != S_ERR) begin
                    case (bus.key_op)
                        OP_DIGIT: begin
                            if (dig_ok) begin
                                display_val <= dig_val[WIDTH-1:0];
                                if (state == S_B) begin
                                    b     <= dig_val[WIDTH-1:0];
                                    b_cnt <= dig_cnt + CW'(1);
                                end else begin
                                    a     <= dig_val[WIDTH-1:0];
                                    a_cnt <= dig_cnt + CW'(1);
                                    fresh <= 1'b0;
                                    neg   <= 1'b0;
                                end
                            end
                        end
                        OP_ENT, OP_DIV, OP_MUL, OP_SUB, OP_ADD: begin
                            if (state == S_A) begin
                                if (chain) begin
                                    if (neg) begin
                                        state       <= S_ERR;
                                        err         <= 1'b1;
                                        display_val <= '0;
                                        cur_op      <= '0;
                                    end else begin
                                        cur_op <= bus.key_op;
                                        b      <= '0;
                                        b_cnt  <= '0;
                                        fresh  <= 1'b0;
                                        state  <= S_B;
                                    end
                                end
                            end else if (chain && b_cnt == '0) begin
                                cur_op <= bus.key_op;
                            end else if (alu_err || (chain && alu_neg)) begin
                                state       <= S_ERR;
                                err         <= 1'b1;
                                display_val <= '0;
                                cur_op      <= '0;
                            end else if (cur_op == OP_DIV) begin
                                // The acknowledge is withheld until the divider finishes.
                                state     <= S_DIV;
                                busy      <= 1'b1;
                                ack       <= 1'b0;
                                div_rem   <= '0;
                                div_quo   <= a;
                                div_cnt   <= '0;
                                div_chain <= chain;
                                next_op   <= bus.key_op;
                            end else begin
                                a           <= alu_res;
                                display_val <= alu_res;
                                neg         <= alu_neg;
                                if (chain) begin
                                    cur_op <= bus.key_op;
                                    b      <= '0;
                                    b_cnt  <= '0;
                                end else begin
                                    cur_op <= '0;
                                    fresh  <= 1'b1;
                                    state  <= S_A;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_calc_engine.sv
// Self-checking bench for calc_engine: directed token sequences, a
// behavioural calculator model, and literal expectations on key results.
module tb_calc_engine;
    localparam int     W     = 16;
    localparam int     MAXD  = 5;
    localparam longint MAXV  = (longint'(1) << W) - 1;
    localparam int     K_DIG = 0;
    localparam int     K_DIV = 1;
    localparam int     K_ENT = 2;
    localparam int     K_CLR = 3;
    localparam int     K_MUL = 4;
    localparam int     K_SUB = 5;
    localparam int     K_ADD = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    bit   valid    = 1'b0;

    // Model state: mode 0 = entering A, 1 = entering B, 2 = error held.
    longint m_a, m_b, m_disp, m_rem;
    int     m_op, m_neg, m_err, m_fresh, m_acnt, m_bcnt, m_mode;

    // Free-running clock.
    always #5 clk = ~clk;

    calc_engine_if #(.WIDTH(W)) bus ();
    calc_engine_if #(.WIDTH(W)) bus3 ();

    calc_engine #(.WIDTH(W), .MAX_DIGITS(MAXD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    calc_engine #(.WIDTH(W), .MAX_DIGITS(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_a = 0; m_b = 0; m_disp = 0; m_rem = 0;
        m_op = 0; m_neg = 0; m_err = 0; m_fresh = 0;
        m_acnt = 0; m_bcnt = 0; m_mode = 0;
    endfunction

    function automatic void model_error();
        m_err = 1; m_disp = 0; m_op = 0; m_mode = 2;
    endfunction

    // Applies one token to the model; returns 1 when the token completes through a divide.
    function automatic bit model_token(input int op, input int num);
        bit     did_div = 1'b0;
        bit     ng = 1'b0;
        bit     er = 1'b0;
        longint base, v, res;
        int     cnt;
        if (op == K_CLR) begin
            model_reset();
            return 1'b0;
        end
        if (m_mode == 2) return 1'b0;
        if (op == K_DIG) begin
            base = (m_mode == 0) ? (m_fresh != 0 ? 0 : m_a) : m_b;
            cnt  = (m_mode == 0) ? (m_fresh != 0 ? 0 : m_acnt) : m_bcnt;
            v    = base * 10 + num;
            if (num <= 9 && cnt < MAXD && v <= MAXV) begin
                if (m_mode == 0) begin
                    m_a = v; m_acnt = cnt + 1; m_fresh = 0; m_neg = 0;
                end else begin
                    m_b = v; m_bcnt = cnt + 1;
                end
                m_disp = v;
            end
        end else if (op == K_ENT || op == K_DIV || op == K_MUL || op == K_SUB || op == K_ADD) begin
            if (m_mode == 0) begin
                if (op != K_ENT) begin
                    if (m_neg != 0) model_error();
                    else begin
                        m_op = op; m_b = 0; m_bcnt = 0; m_fresh = 0; m_mode = 1;
                    end
                end
            end else if (op != K_ENT && m_bcnt == 0) begin
                m_op = op;
            end else begin
                res = 0;
                if (m_op == K_ADD) begin
                    res = m_a + m_b; er = (res > MAXV);
                end else if (m_op == K_SUB) begin
                    if (m_a >= m_b) res = m_a - m_b;
                    else begin res = m_b - m_a; ng = 1'b1; end
                end else if (m_op == K_MUL) begin
                    res = m_a * m_b; er = (res > MAXV);
                end else begin
                    if (m_b == 0) er = 1'b1;
                    else begin res = m_a / m_b; did_div = 1'b1; end
                end
                if (er || (op != K_ENT && ng)) begin
                    model_error();
                    did_div = 1'b0;
                end else begin
                    if (did_div) m_rem = m_a % m_b;
                    m_a = res; m_disp = res; m_neg = int'(ng);
                    if (op == K_ENT) begin
                        m_op = 0; m_fresh = 1; m_mode = 0;
                    end else begin
                        m_op = op; m_b = 0; m_bcnt = 0;
                    end
                end
            end
        end
        return did_div;
    endfunction

    // Continuous comparison of the held outputs against the model between tokens.
    always @(negedge clk) begin
        #1;
        if (valid && rst_n) begin
            checkOutput("display_val", bus.display_val, m_disp);
            checkOutput("remainder", bus.remainder, m_rem);
            checkOutput("cur_op", bus.cur_op, m_op);
            checkOutput("neg", bus.neg, m_neg);
            checkOutput("err", bus.err, m_err);
            checkOutput("busy_idle", bus.busy, 0);
        end
    end

    // Drives one token through the full four-phase handshake and checks its timing;
    // drop_after > 0 releases req that many cycles after raising it.
    task automatic applyStimulus(input int op, input int num, input int drop_after);
        bit is_div;
        int n = 0;
        int busy_n = 0;
        @(negedge clk);
        valid = 1'b0;
        is_div = model_token(op, num);
        bus.key_op  = 3'(op);
        bus.key_num = 4'(num);
        bus.req     = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (bus.busy) busy_n++;
            if (drop_after > 0 && n == drop_after) bus.req = 1'b0;
        end while (!bus.ack && n < 100);
        checkOutput("ack_latency", n, is_div ? W + 1 : 1);
        checkOutput("busy_cycles", busy_n, is_div ? W : 0);
        bus.req = 1'b0;
        valid   = 1'b1;
        @(negedge clk);
        checkOutput("ack_fall", bus.ack, 0);
    endtask

    // Enters a decimal number digit by digit.
    task automatic enterNumber(input int v);
        string s;
        s = $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) applyStimulus(K_DIG, int'(s[i]) - 48, 0);
    endtask

    // Digit handshake on the three-digit instance.
    task automatic press3(input int num);
        int n = 0;
        @(negedge clk);
        bus3.key_op  = 3'd0;
        bus3.key_num = 4'(num);
        bus3.req     = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus3.ack && n < 50);
        checkOutput("dut3_ack", bus3.ack, 1);
        bus3.req = 1'b0;
        @(negedge clk);
    endtask

    // Starts a divide with ENT and asserts reset five edges into it.
    task automatic resetMidDivide();
        @(negedge clk);
        valid = 1'b0;
        bus.key_op = 3'(K_ENT);
        bus.req    = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2;
        checkOutput("busy_before_reset", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_display", bus.display_val, 0);
        checkOutput("rst_remainder", bus.remainder, 0);
        checkOutput("rst_cur_op", bus.cur_op, 0);
        checkOutput("rst_neg", bus.neg, 0);
        checkOutput("rst_err", bus.err, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_ack", bus.ack, 0);
        bus.req = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        bus.req = 1'b0;  bus.key_op = 3'd0;  bus.key_num = 4'd0;
        bus3.req = 1'b0; bus3.key_op = 3'd0; bus3.key_num = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        checkOutput("reset_display", bus.display_val, 0);
        checkOutput("reset_remainder", bus.remainder, 0);
        checkOutput("reset_cur_op", bus.cur_op, 0);
        checkOutput("reset_flags", {bus.ack, bus.busy, bus.neg, bus.err}, 0);
        rst_n = 1'b1;
        valid = 1'b1;

        // Basic add and handshake.
        applyStimulus(K_DIG, 1, 0);
        applyStimulus(K_DIG, 2, 0);
        checkOutput("add_a", bus.display_val, 12);
        applyStimulus(K_ADD, 0, 0);
        checkOutput("add_op_disp", bus.display_val, 12);
        checkOutput("add_op", bus.cur_op, K_ADD);
        applyStimulus(K_DIG, 3, 0);
        checkOutput("add_b1", bus.display_val, 3);
        applyStimulus(K_DIG, 4, 0);
        checkOutput("add_b2", bus.display_val, 34);
        applyStimulus(K_ENT, 0, 0);
        checkOutput("add_result", bus.display_val, 46);
        checkOutput("add_neg", bus.neg, 0);

        // Negative result, negative chain error, held error, clear.
        applyStimulus(K_DIG, 5, 0);
        applyStimulus(K_SUB, 0, 0);
        applyStimulus(K_DIG, 9, 0);
        applyStimulus(K_ENT, 0, 0);
        checkOutput("sub_result", bus.display_val, 4);
        checkOutput("sub_neg", bus.neg, 1);
        applyStimulus(K_ADD, 0, 0);
        checkOutput("negchain_err", bus.err, 1);
        checkOutput("negchain_disp", bus.display_val, 0);
        applyStimulus(K_DIG, 7, 0);
        checkOutput("err_hold_disp", bus.display_val, 0);
        applyStimulus(K_CLR, 0, 0);
        checkOutput("clr_err", bus.err, 0);

        // Multi-cycle divide.
        enterNumber(1000);
        applyStimulus(K_DIV, 0, 0);
        applyStimulus(K_DIG, 7, 0);
        applyStimulus(K_ENT, 0, 0);
        checkOutput("div_quotient", bus.display_val, 142);
        checkOutput("div_remainder", bus.remainder, 6);

        // Chained divide with req released while the divider runs.
        applyStimulus(K_CLR, 0, 0);
        enterNumber(100);
        applyStimulus(K_DIV, 0, 0);
        applyStimulus(K_DIG, 7, 0);
        applyStimulus(K_ADD, 0, 3);
        checkOutput("chaindiv_disp", bus.display_val, 14);
        checkOutput("chaindiv_rem", bus.remainder, 2);
        applyStimulus(K_DIG, 1, 0);
        applyStimulus(K_ENT, 0, 0);
        checkOutput("chaindiv_result", bus.display_val, 15);

        // Divide by zero: error without entering the divider.
        applyStimulus(K_CLR, 0, 0);
        applyStimulus(K_DIG, 9, 0);
        applyStimulus(K_DIV, 0, 0);
        applyStimulus(K_DIG, 0, 0);
        applyStimulus(K_ENT, 0, 0);
        checkOutput("div0_err", bus.err, 1);

        // Multiply overflow.
        applyStimulus(K_CLR, 0, 0);
        enterNumber(300);
        applyStimulus(K_MUL, 0, 0);
        enterNumber(300);
        applyStimulus(K_ENT, 0, 0);
        checkOutput("mul_ovf_err", bus.err, 1);

        // Value limit on digit entry.
        applyStimulus(K_CLR, 0, 0);
        enterNumber(65536);
        checkOutput("digit_limit", bus.display_val, 6553);

        // Digit-count limit on the three-digit instance.
        press3(1);
        press3(2);
        press3(3);
        press3(4);
        checkOutput("dut3_digits", bus3.display_val, 123);

        // Chaining and fresh restart.
        applyStimulus(K_CLR, 0, 0);
        applyStimulus(K_DIG, 2, 0);
        applyStimulus(K_ADD, 0, 0);
        applyStimulus(K_DIG, 3, 0);
        applyStimulus(K_MUL, 0, 0);
        checkOutput("chain_partial", bus.display_val, 5);
        applyStimulus(K_DIG, 4, 0);
        applyStimulus(K_ENT, 0, 0);
        checkOutput("chain_result", bus.display_val, 20);
        applyStimulus(K_DIG, 5, 0);
        checkOutput("fresh_restart", bus.display_val, 5);

        // Reset asserted in the middle of a divide.
        applyStimulus(K_DIG, 8, 0);
        applyStimulus(K_DIV, 0, 0);
        applyStimulus(K_DIG, 3, 0);
        resetMidDivide();
        applyStimulus(K_DIG, 7, 0);
        checkOutput("post_reset_digit", bus.display_val, 7);
        applyStimulus(K_ENT, 0, 0);
        checkOutput("post_reset_ent", bus.display_val, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
